decoder_scan_n: RTL and testbench

Parametrised, registered successor to the team's 3-to-8 enable-gated decoder. It generalises width to ADDR_W inputs and 2**ADDR_W active-low outputs, and keeps the three-enable gating (E1/E2 active-low, E3 active-high). It adds a built-in scan sequencer, so the block can walk its outputs itself. Typical uses are display digit or row scanning and chip-select sequencing.

---
 rtl/decoder_scan_n_if.sv | 32 +++
 rtl/decoder_scan_n.sv | 175 +++++++++++++++++
 tb/tb_decoder_scan_n.sv | 352 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/decoder_scan_n_if.sv
// rtl/decoder_scan_n_if.sv - select, enable, scan-control and decode signals of decoder_scan_n
interface decoder_scan_n_if #(
  parameter int ADDR_W  = 3,
  parameter int DWELL_W = 8
);
  localparam int OUT_N = 1 << ADDR_W;

  // control side
  logic [ADDR_W-1:0]  DataIn;
  logic               E1;
  logic               E2;
  logic               E3;
  logic [1:0]         Mode;
  logic [DWELL_W-1:0] Dwell;
  logic               Start;

  // decode side
  logic [OUT_N-1:0]   Dataout;
  logic [ADDR_W-1:0]  Index;
  logic               Busy;
  logic               Done;

  modport master (
    output DataIn, E1, E2, E3, Mode, Dwell, Start,
    input  Dataout, Index, Busy, Done
  );

  modport slave (
    input  DataIn, E1, E2, E3, Mode, Dwell, Start,
    output Dataout, Index, Busy, Done
  );
endinterface

// File: rtl/decoder_scan_n.sv
// rtl/decoder_scan_n.sv - registered active-low N-way decoder with built-in scan and sweep sequencer
module decoder_scan_n #(
  parameter int ADDR_W  = 3,
  parameter int DWELL_W = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  decoder_scan_n_if.slave  bus
);
  localparam int OUT_N = 1 << ADDR_W;

  localparam logic [1:0] MODE_DIRECT = 2'b00;
  localparam logic [1:0] MODE_SCAN   = 2'b01;
  localparam logic [1:0] MODE_SWEEP  = 2'b10;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(OUT_N - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SWEEP,
    S_FINISH
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  idx_q, idx_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [DWELL_W-1:0] lim_q, lim_d;
  logic [OUT_N-1:0]   dout_q, dout_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [1:0]         mode_q;

  logic [1:0]         mode_eff;
  logic               mode_chg;
  logic               en;
  logic               dwell_end;

  // Single zero at position i, everything else high.
  function automatic logic [OUT_N-1:0] onecold(input logic [ADDR_W-1:0] i);
    logic [OUT_N-1:0] v;
    v    = '1;
    v[i] = 1'b0;
    return v;
  endfunction

  // Last counter value of a channel; a dwell of zero behaves like one.
  function automatic logic [DWELL_W-1:0] lim_of(input logic [DWELL_W-1:0] d);
    return (d == '0) ? '0 : d - DWELL_W'(1);
  endfunction

  // The reserved mode code behaves as direct, so 00<->11 is not a mode change.
  assign mode_eff  = (bus.Mode == 2'b11) ? MODE_DIRECT : bus.Mode;
  assign mode_chg  = (mode_eff != mode_q);
  assign en        = !bus.E1 && !bus.E2 && bus.E3;
  assign dwell_end = (cnt_q == lim_q);

  // State, channel, dwell and output registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      lim_q   <= '0;
      dout_q  <= '1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      mode_q  <= MODE_DIRECT;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      lim_q   <= lim_d;
      dout_q  <= dout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      mode_q  <= mode_eff;
    end
  end

  // Next channel, dwell count, sweep state and decoded outputs for the coming edge.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    lim_d   = lim_q;
    dout_d  = '1;
    busy_d  = busy_q;
    done_d  = 1'b0;

    // A mode change abandons any sweep silently and restarts dwell timing.
    if (mode_chg) begin
      state_d = S_IDLE;
      busy_d  = 1'b0;
      cnt_d   = '0;
      lim_d   = lim_of(bus.Dwell);
    end

    case (mode_eff)
      MODE_SCAN: begin
        if (mode_chg) begin
          idx_d = '0;
          if (en) dout_d = onecold('0);
        end else if (en) begin
          if (dwell_end) begin
            idx_d = idx_q + ADDR_W'(1);
            cnt_d = '0;
            lim_d = lim_of(bus.Dwell);
          end else begin
            cnt_d = cnt_q + DWELL_W'(1);
          end
          dout_d = onecold(idx_d);
        end
      end

      MODE_SWEEP: begin
        if (mode_chg) begin
          // Arriving in sweep mode lands in IDLE; a Start on this edge is not taken.
          idx_d = '0;
        end else begin
          case (state_q)
            S_IDLE: begin
              if (bus.Start && en) begin
                state_d = S_SWEEP;
                idx_d   = '0;
                cnt_d   = '0;
                lim_d   = lim_of(bus.Dwell);
                busy_d  = 1'b1;
                dout_d  = onecold('0);
              end
            end
            S_SWEEP: begin
              // With enables off the sweep pauses in place.
              if (en) begin
                if (dwell_end) begin
                  if (idx_q == LAST_IDX) begin
                    state_d = S_FINISH;
                    idx_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                  end else begin
                    idx_d  = idx_q + ADDR_W'(1);
                    cnt_d  = '0;
                    lim_d  = lim_of(bus.Dwell);
                    dout_d = onecold(idx_d);
                  end
                end else begin
                  cnt_d  = cnt_q + DWELL_W'(1);
                  dout_d = onecold(idx_q);
                end
              end
            end
            S_FINISH: begin
              state_d = S_IDLE;
            end
            default: begin
              state_d = S_IDLE;
              busy_d  = 1'b0;
            end
          endcase
        end
      end

      default: begin
        idx_d = bus.DataIn;
        if (en) dout_d = onecold(bus.DataIn);
      end
    endcase
  end

  assign bus.Dataout = dout_q;
  assign bus.Index   = idx_q;
  assign bus.Busy    = busy_q;
  assign bus.Done    = done_q;
endmodule

// File: tb/tb_decoder_scan_n.sv
// tb/tb_decoder_scan_n.sv - scoreboard bench for decoder_scan_n at ADDR_W=3 and ADDR_W=1
module tb_decoder_scan_n;
  logic       clk;
  logic       rst;
  logic [2:0] din;
  logic       e1, e2, e3;
  logic [1:0] mode;
  logic [7:0] dwell;
  logic       start;

  int total = 0;
  int bad   = 0;
  int busy3_n, done3_n, busy1_n, done1_n;

  decoder_scan_n_if #(.ADDR_W(3), .DWELL_W(8)) ifc3 ();
  decoder_scan_n_if #(.ADDR_W(1), .DWELL_W(8)) ifc1 ();

  assign ifc3.DataIn = din;
  assign ifc3.E1     = e1;
  assign ifc3.E2     = e2;
  assign ifc3.E3     = e3;
  assign ifc3.Mode   = mode;
  assign ifc3.Dwell  = dwell;
  assign ifc3.Start  = start;

  assign ifc1.DataIn = din[0];
  assign ifc1.E1     = e1;
  assign ifc1.E2     = e2;
  assign ifc1.E3     = e3;
  assign ifc1.Mode   = mode;
  assign ifc1.Dwell  = dwell;
  assign ifc1.Start  = start;

  decoder_scan_n #(.ADDR_W(3), .DWELL_W(8)) dut3 (.Clk(clk), .Reset(rst), .bus(ifc3.slave));
  decoder_scan_n #(.ADDR_W(1), .DWELL_W(8)) dut1 (.Clk(clk), .Reset(rst), .bus(ifc1.slave));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference state: phase 0 idle, 1 sweeping, 2 finishing; left = cycles still to show the channel.
  typedef struct {
    int idx;
    int phase;
    int left;
    int prevm;
    bit busy;
    bit done;
    bit lit;
  } mstate_t;

  typedef struct {
    logic [63:0] dout;
    int          idx;
    bit          busy;
    bit          done;
  } exp_t;

  mstate_t ms3, ms1;
  exp_t    q3[$];
  exp_t    q1[$];
  exp_t    got3, got1;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endfunction

  function automatic mstate_t ms_reset();
    mstate_t s;
    s = '{idx: 0, phase: 0, left: 0, prevm: 0, busy: 0, done: 0, lit: 0};
    return s;
  endfunction

  // Behaviour at one clock edge, given the inputs currently applied.
  function automatic mstate_t mstep(mstate_t s, int out_n);
    mstate_t n;
    int      m;
    int      dw;
    bit      en;
    if (rst) return ms_reset();
    n      = s;
    n.done = 0;
    n.lit  = 0;
    m  = (mode == 2'b11) ? 0 : int'(mode);
    dw = (dwell == 0) ? 1 : int'(dwell);
    en = !e1 && !e2 && e3;
    if (m != s.prevm) begin
      n.prevm = m;
      n.phase = 0;
      n.busy  = 0;
      n.idx   = 0;
      n.left  = dw;
      if (m == 0) begin
        n.idx = int'(din) % out_n;
        n.lit = en;
      end else if (m == 1) begin
        n.lit = en;
      end
      return n;
    end
    if (m == 0) begin
      n.idx = int'(din) % out_n;
      n.lit = en;
    end else if (m == 1) begin
      if (en) begin
        if (s.left <= 1) begin
          n.idx  = (s.idx + 1) % out_n;
          n.left = dw;
        end else begin
          n.left = s.left - 1;
        end
        n.lit = 1;
      end
    end else begin
      if (s.phase == 0) begin
        if (start && en) begin
          n.phase = 1;
          n.idx   = 0;
          n.left  = dw;
          n.busy  = 1;
          n.lit   = 1;
        end
      end else if (s.phase == 1) begin
        if (en) begin
          if (s.left <= 1) begin
            if (s.idx == out_n - 1) begin
              n.phase = 2;
              n.idx   = 0;
              n.busy  = 0;
              n.done  = 1;
            end else begin
              n.idx  = s.idx + 1;
              n.left = dw;
              n.lit  = 1;
            end
          end else begin
            n.left = s.left - 1;
            n.lit  = 1;
          end
        end
      end else begin
        n.phase = 0;
      end
    end
    return n;
  endfunction

  function automatic exp_t mk_exp(mstate_t s, int out_n);
    exp_t        e;
    logic [63:0] mask;
    mask   = (64'd1 << out_n) - 64'd1;
    e.dout = s.lit ? (mask & ~(64'd1 << s.idx)) : mask;
    e.idx  = s.idx;
    e.busy = s.busy;
    e.done = s.done;
    return e;
  endfunction

  // Issue one edge: predict both DUTs, queue the predictions, let the edge happen.
  task automatic cyc();
    ms3 = mstep(ms3, 8);
    ms1 = mstep(ms1, 2);
    q3.push_back(mk_exp(ms3, 8));
    q1.push_back(mk_exp(ms1, 2));
    @(posedge clk);
    #2;
  endtask

  // Raise Reset between edges and check it acts without waiting for the clock.
  task automatic async_reset();
    #3;
    rst = 1'b1;
    #1;
    chk("async Dataout3", ifc3.Dataout, 64'hFF);
    chk("async Index3", ifc3.Index, 0);
    chk("async Busy3", ifc3.Busy, 0);
    chk("async Done3", ifc3.Done, 0);
    chk("async Dataout1", ifc1.Dataout, 64'h3);
    ms3 = ms_reset();
    ms1 = ms_reset();
  endtask

  task automatic clear_counts();
    busy3_n = 0;
    done3_n = 0;
    busy1_n = 0;
    done1_n = 0;
  endtask

  // Monitor: after each edge, compare whatever prediction is waiting.
  always @(posedge clk) begin
    #1;
    if (q3.size() > 0) begin
      got3 = q3.pop_front();
      chk("dut3 Dataout", ifc3.Dataout, got3.dout);
      chk("dut3 Index", ifc3.Index, got3.idx);
      chk("dut3 Busy", ifc3.Busy, got3.busy);
      chk("dut3 Done", ifc3.Done, got3.done);
      if (ifc3.Busy) busy3_n++;
      if (ifc3.Done) done3_n++;
    end
    if (q1.size() > 0) begin
      got1 = q1.pop_front();
      chk("dut1 Dataout", ifc1.Dataout, got1.dout);
      chk("dut1 Index", ifc1.Index, got1.idx);
      chk("dut1 Busy", ifc1.Busy, got1.busy);
      chk("dut1 Done", ifc1.Done, got1.done);
      if (ifc1.Busy) busy1_n++;
      if (ifc1.Done) done1_n++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst   = 1'b0;
    din   = 3'd5;
    e1    = 1'b0;
    e2    = 1'b0;
    e3    = 1'b1;
    mode  = 2'b00;
    dwell = 8'd3;
    start = 1'b0;
    ms3   = ms_reset();
    ms1   = ms_reset();
    clear_counts();

    #1 rst = 1'b1;
    #1;
    chk("reset Dataout3", ifc3.Dataout, 64'hFF);
    chk("reset Index3", ifc3.Index, 0);
    chk("reset Busy3", ifc3.Busy, 0);
    chk("reset Done3", ifc3.Done, 0);
    chk("reset Dataout1", ifc1.Dataout, 64'h3);
    @(posedge clk);
    #2;
    rst = 1'b0;

    // enable gating in direct mode
    cyc();
    e3 = 1'b0; cyc();
    e3 = 1'b1; e1 = 1'b1; cyc();
    e1 = 1'b0; e2 = 1'b1; cyc();
    e2 = 1'b0; cyc();
    async_reset();
    cyc();
    rst = 1'b0;

    // walking zero, then random direct decode including the reserved mode
    for (int i = 0; i < 8; i++) begin
      din = 3'(i);
      cyc();
    end
    for (int i = 0; i < 24; i++) begin
      din  = 3'($urandom);
      mode = ($urandom_range(0, 3) == 0) ? 2'b11 : 2'b00;
      e1   = ($urandom_range(0, 5) == 0);
      e3   = ($urandom_range(0, 5) != 0);
      cyc();
    end
    mode = 2'b00; e1 = 1'b0; e2 = 1'b0; e3 = 1'b1;
    cyc();

    // continuous scan, a pause mid-channel, then dwell of zero
    mode = 2'b01; dwell = 8'd3;
    for (int i = 0; i < 26; i++) cyc();
    e2 = 1'b1;
    for (int i = 0; i < 5; i++) cyc();
    e2 = 1'b0;
    for (int i = 0; i < 12; i++) cyc();
    dwell = 8'd0;
    for (int i = 0; i < 12; i++) cyc();
    for (int i = 0; i < 40; i++) begin
      dwell = 8'($urandom_range(0, 4));
      e2    = ($urandom_range(0, 4) == 0);
      cyc();
    end
    e2 = 1'b0;

    // single sweep with a second Start while busy
    mode = 2'b10; dwell = 8'd2;
    for (int i = 0; i < 3; i++) cyc();
    clear_counts();
    start = 1'b1;
    cyc();
    for (int i = 1; i <= 24; i++) begin
      start = (i == 2);
      cyc();
    end
    start = 1'b0;
    chk("sweep busy cycles dut3", busy3_n, 16);
    chk("sweep done pulses dut3", done3_n, 1);
    chk("sweep busy cycles dut1", busy1_n, 4);
    chk("sweep done pulses dut1", done1_n, 1);

    // reset at channel 4 of a sweep
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 8; i++) cyc();
    chk("abort channel dut3", ifc3.Index, 4);
    clear_counts();
    async_reset();
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) cyc();
    chk("no done after reset dut3", done3_n, 0);

    // mode change 10 -> 00 mid-sweep
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 5; i++) cyc();
    clear_counts();
    mode = 2'b00;
    for (int i = 0; i < 10; i++) begin
      din = 3'($urandom);
      cyc();
    end
    chk("no done after mode change dut3", done3_n, 0);

    // random soak across all modes
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 19) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) dwell = 8'($urandom_range(0, 4));
      din   = 3'($urandom);
      e1    = ($urandom_range(0, 9) == 0);
      e2    = ($urandom_range(0, 9) == 0);
      e3    = ($urandom_range(0, 9) != 0);
      start = ($urandom_range(0, 7) == 0);
      rst   = ($urandom_range(0, 99) == 0);
      cyc();
    end
    rst   = 1'b0;
    start = 1'b0;
    cyc();

    chk("queue3 drained", q3.size(), 0);
    chk("queue1 drained", q1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
